// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the traffic light monitor:
//   - light codes for one road (RED/YELLOW/GREEN, code 3 is illegal)
//   - the five legal {highway, small_road} phase combos of the light ring
//   - monitor FSM state encoding
//   - fault codes (lower code = higher priority)
//   - ring helpers: successor combo and successor state
// -----------------------------------------------------------------------------
package traffic_pkg;

    localparam logic [1:0] LIGHT_RED    = 2'd0;
    localparam logic [1:0] LIGHT_YELLOW = 2'd1;
    localparam logic [1:0] LIGHT_GREEN  = 2'd2;
    localparam logic [1:0] LIGHT_BAD    = 2'd3;

    // Phase combos, {highway, small_road}
    localparam logic [3:0] P_HG = {LIGHT_GREEN,  LIGHT_RED};
    localparam logic [3:0] P_HY = {LIGHT_YELLOW, LIGHT_RED};
    localparam logic [3:0] P_AR = {LIGHT_RED,    LIGHT_RED};
    localparam logic [3:0] P_SG = {LIGHT_RED,    LIGHT_GREEN};
    localparam logic [3:0] P_SY = {LIGHT_RED,    LIGHT_YELLOW};

    localparam logic [3:0] DWELL_MAX = 4'd15;

    typedef enum logic [2:0] {
        M_SYNC  = 3'd0,
        M_HG    = 3'd1,
        M_HY    = 3'd2,
        M_AR    = 3'd3,
        M_SG    = 3'd4,
        M_SY    = 3'd5,
        M_FAULT = 3'd6
    } mon_state_t;

    localparam logic [2:0] FC_NONE      = 3'd0;
    localparam logic [2:0] FC_BAD_CODE  = 3'd1;
    localparam logic [2:0] FC_CONFLICT  = 3'd2;
    localparam logic [2:0] FC_BAD_TRANS = 3'd3;
    localparam logic [2:0] FC_SHORT_YEL = 3'd4;
    localparam logic [2:0] FC_SHORT_AR  = 3'd5;
    localparam logic [2:0] FC_SENSOR    = 3'd6;

    // The only combo allowed to follow c on the ring.
    function automatic logic [3:0] ring_next(input logic [3:0] c);
        logic [3:0] n;
        case (c)
            P_HG:    n = P_HY;
            P_HY:    n = P_AR;
            P_AR:    n = P_SG;
            P_SG:    n = P_SY;
            default: n = P_HG;
        endcase
        return n;
    endfunction

    // Monitor state that tracks the next ring phase.
    function automatic mon_state_t state_next(input mon_state_t s);
        mon_state_t n;
        case (s)
            M_HG:    n = M_HY;
            M_HY:    n = M_AR;
            M_AR:    n = M_SG;
            M_SG:    n = M_SY;
            M_SY:    n = M_HG;
            default: n = s;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/tl_dwell_counter.sv
// -----------------------------------------------------------------------------
// tl_dwell_counter
// Counts how many consecutive samples the current light combo has been held.
//   clk   : clock
//   clr   : asynchronous active-high reset, count -> 0
//   load  : combo changed this sample, count -> 1
//   dwell : current count, increments otherwise and saturates at 15
// -----------------------------------------------------------------------------
module tl_dwell_counter
    import traffic_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       load,
    output logic [3:0] dwell
);

    logic [3:0] dwell_reg;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            dwell_reg <= 4'd0;
        end else if (load) begin
            dwell_reg <= 4'd1;
        end else if (dwell_reg != DWELL_MAX) begin
            dwell_reg <= dwell_reg + 4'd1;
        end
    end

    assign dwell = dwell_reg;

endmodule

// File: rtl/traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// traffic_light_monitor
// Watches the highway / small-road light outputs of a traffic controller and
// latches the first protocol violation (illegal code, conflicting greens,
// illegal ring step, short yellow, short all-red, optionally ignored sensor).
//
// Parameters:
//   MIN_YELLOW : minimum samples any yellow phase must be held (1..15)
//   MIN_ALLRED : minimum samples the all-red phase must be held (1..15)
// Ports:
//   clk         : clock
//   clr         : asynchronous active-high reset
//   highway     : highway light code
//   small_road  : small-road light code
//   sensor      : small-road vehicle sensor as seen by the controller
//   fault_clr   : synchronous clear of fault / fault_code, re-enters sync
//   fault       : sticky fault flag
//   fault_code  : code of the first fault since the last clear
//   phase_count : completed light cycles (SY -> HG), saturates at 255
// Build option:
//   MON_SENSOR_CHECK_EN : when defined, a small-road green held while the
//                         sensor reads 0 for two consecutive samples raises
//                         fault code 6. Undefined: sensor is ignored.
// -----------------------------------------------------------------------------
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 2,
    parameter int MIN_ALLRED = 1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] highway,
    input  logic [1:0] small_road,
    input  logic       sensor,
    input  logic       fault_clr,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] phase_count
);

    localparam logic [3:0] MIN_YEL_L = 4'(MIN_YELLOW);
    localparam logic [3:0] MIN_AR_L  = 4'(MIN_ALLRED);

    mon_state_t state_reg;
    logic [3:0] prev_combo_reg;
    logic       fault_reg;
    logic [2:0] fault_code_reg;
    logic [7:0] phase_count_reg;

    logic [3:0] combo;
    logic       changed;
    logic [3:0] dwell;
    logic [2:0] det_code;

`ifdef MON_SENSOR_CHECK_EN
    // Previous sample was a legal small-road green with the sensor low.
    logic sensor_low_reg;
`else
    logic sensor_unused;
    assign sensor_unused = sensor;
`endif

    assign combo   = {highway, small_road};
    assign changed = (combo != prev_combo_reg);

    // dwell holds the sample count of prev_combo, i.e. of the phase being
    // left when changed is high.
    tl_dwell_counter u_dwell (
        .clk   (clk),
        .clr   (clr),
        .load  (changed),
        .dwell (dwell)
    );

    // Fault detection; the if/else order gives lower codes priority.
    always_comb begin
        det_code = FC_NONE;
        if (state_reg != M_FAULT) begin
            if (highway == LIGHT_BAD || small_road == LIGHT_BAD) begin
                det_code = FC_BAD_CODE;
            end else if (highway != LIGHT_RED && small_road != LIGHT_RED) begin
                det_code = FC_CONFLICT;
            end else if (state_reg != M_SYNC) begin
                if (changed) begin
                    if (combo != ring_next(prev_combo_reg)) begin
                        det_code = FC_BAD_TRANS;
                    end else if ((state_reg == M_HY || state_reg == M_SY) &&
                                 dwell < MIN_YEL_L) begin
                        det_code = FC_SHORT_YEL;
                    end else if (state_reg == M_AR && dwell < MIN_AR_L) begin
                        det_code = FC_SHORT_AR;
                    end
                end
`ifdef MON_SENSOR_CHECK_EN
                else if (state_reg == M_SG && !sensor && sensor_low_reg) begin
                    det_code = FC_SENSOR;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg       <= M_SYNC;
            prev_combo_reg  <= P_HG;
            fault_reg       <= 1'b0;
            fault_code_reg  <= FC_NONE;
            phase_count_reg <= 8'd0;
`ifdef MON_SENSOR_CHECK_EN
            sensor_low_reg  <= 1'b0;
`endif
        end else begin
            prev_combo_reg <= combo;
`ifdef MON_SENSOR_CHECK_EN
            // Entry sample from all-red counts as the first low sample.
            sensor_low_reg <= !sensor && (combo == P_SG) &&
                              (state_reg == M_AR || state_reg == M_SG);
`endif
            if (fault_clr) begin
                // Clear wins over a fault detected on the same sample.
                state_reg      <= M_SYNC;
                fault_reg      <= 1'b0;
                fault_code_reg <= FC_NONE;
            end else if (det_code != FC_NONE) begin
                state_reg      <= M_FAULT;
                fault_reg      <= 1'b1;
                fault_code_reg <= det_code;
            end else begin
                case (state_reg)
                    M_SYNC: begin
                        if (combo == P_HG) begin
                            state_reg <= M_HG;
                        end
                    end
                    M_FAULT: begin
                        state_reg <= M_FAULT;
                    end
                    default: begin
                        // No fault on a change means a legal ring step.
                        if (changed) begin
                            state_reg <= state_next(state_reg);
                            if (state_reg == M_SY && phase_count_reg != 8'hFF) begin
                                phase_count_reg <= phase_count_reg + 8'd1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign fault       = fault_reg;
    assign fault_code  = fault_code_reg;
    assign phase_count = phase_count_reg;

endmodule

// File: tb/tb_traffic_light_monitor.sv
module tb_traffic_light_monitor;

    localparam int MIN_Y = 2;
    localparam int MIN_A = 1;

    localparam logic [3:0] HG = 4'b1000;
    localparam logic [3:0] HY = 4'b0100;
    localparam logic [3:0] AR = 4'b0000;
    localparam logic [3:0] SG = 4'b0010;
    localparam logic [3:0] SY = 4'b0001;

    logic [3:0] ring [5];
    int         min_dwell [5];

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] highway = 2'd0;
    logic [1:0] small_road = 2'd0;
    logic       sensor = 1'b1;
    logic       fault_clr = 1'b0;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] phase_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: ring position index, run length, sticky fault.
    int         m_synced, m_faulted, m_pos, m_run, m_low, m_count;
    logic [3:0] m_last;
    logic [2:0] m_code;

    traffic_light_monitor #(
        .MIN_YELLOW (MIN_Y),
        .MIN_ALLRED (MIN_A)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .highway     (highway),
        .small_road  (small_road),
        .sensor      (sensor),
        .fault_clr   (fault_clr),
        .fault       (fault),
        .fault_code  (fault_code),
        .phase_count (phase_count)
    );

    always #5 clk = ~clk;

    function automatic int ring_index(input logic [3:0] c);
        for (int i = 0; i < 5; i++) if (ring[i] == c) return i;
        return -1;
    endfunction

    function automatic logic [3:0] succ(input logic [3:0] c);
        int idx;
        idx = ring_index(c);
        if (idx < 0) return HG;
        return ring[(idx + 1) % 5];
    endfunction

    task automatic model_reset();
        m_synced = 0; m_faulted = 0; m_pos = 0; m_run = 0; m_low = 0;
        m_count = 0; m_last = HG; m_code = 3'd0;
    endtask

    task automatic model_step(input logic [1:0] hw, input logic [1:0] sr,
                              input logic sens, input logic fclr);
        logic [3:0] c;
        int code;
        int idx;
        int new_low;
        c = {hw, sr};
        code = 0;
        idx = ring_index(c);
        if (m_faulted == 0) begin
            if (hw == 2'd3 || sr == 2'd3) code = 1;
            else if (hw != 2'd0 && sr != 2'd0) code = 2;
            else if (m_synced != 0) begin
                if (c != m_last) begin
                    if (idx != (m_pos + 1) % 5) code = 3;
                    else if (m_run < min_dwell[m_pos]) code = (m_pos == 2) ? 5 : 4;
                end
`ifdef MON_SENSOR_CHECK_EN
                else if (m_pos == 3 && !sens && m_low >= 1) code = 6;
`endif
            end
        end
        new_low = (m_synced != 0 && m_faulted == 0 && !sens && c == SG &&
                   (m_pos == 2 || m_pos == 3)) ? m_low + 1 : 0;
        if (fclr) begin
            m_faulted = 0; m_code = 3'd0; m_synced = 0;
        end else if (code != 0) begin
            m_faulted = 1; m_code = 3'(code); m_synced = 0;
        end else if (m_synced == 0 && m_faulted == 0) begin
            if (c == HG) begin m_synced = 1; m_pos = 0; end
        end else if (m_synced != 0 && c != m_last) begin
            m_pos = (m_pos + 1) % 5;
            if (m_pos == 0 && m_count < 255) m_count++;
        end
        m_run  = (c == m_last) ? m_run + 1 : 1;
        m_last = c;
        m_low  = new_low;
    endtask

    // One sample: drive, clock, advance the model, report the transaction.
    task automatic apply(input logic [1:0] hw, input logic [1:0] sr,
                         input logic sens, input logic fclr);
        highway = hw; small_road = sr; sensor = sens; fault_clr = fclr;
        @(posedge clk);
        model_step(hw, sr, sens, fclr);
        #1;
        $display("t=%0t hw=%0d sr=%0d sens=%0b fclr=%0b -> fault=%0b code=%0d count=%0d",
                 $time, hw, sr, sens, fclr, fault, fault_code, phase_count);
    endtask

    task automatic apply_n(input logic [3:0] c, input int n, input logic sens);
        for (int i = 0; i < n; i++) apply(c[3:2], c[1:0], sens, 1'b0);
    endtask

    task automatic min_ring();
        apply_n(HY, MIN_Y, 1'b1); apply_n(AR, MIN_A, 1'b1);
        apply_n(SG, 1, 1'b1); apply_n(SY, MIN_Y, 1'b1); apply_n(HG, 1, 1'b1);
    endtask

    task automatic do_reset();
        clr = 1'b1;
        model_reset();
        #3;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        model_reset();
        #1;
        n_checks++; if (fault !== 1'b0) $display("FAIL reset_fault: got %0b want 0", fault); else n_pass++;
        n_checks++; if (fault_code !== 3'd0) $display("FAIL reset_code: got %0d want 0", fault_code); else n_pass++;
        n_checks++; if (phase_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", phase_count); else n_pass++;
        #2;
        clr = 1'b0;
    endtask

    task automatic test_legal_ring();
        do_reset();
        for (int rep = 0; rep < 3; rep++) begin
            apply_n(HG, 4, 1'b1); apply_n(HY, 2, 1'b1); apply_n(AR, 1, 1'b1);
            apply_n(SG, 3, 1'b1); apply_n(SY, 2, 1'b1);
        end
        apply_n(HG, 1, 1'b1);
        n_checks++; if (fault !== 1'b0) $display("FAIL ring_fault: got %0b want 0", fault); else n_pass++;
        n_checks++; if (phase_count !== 8'd3) $display("FAIL ring_count: got %0d want 3", phase_count); else n_pass++;
    endtask

    task automatic test_short_yellow();
        do_reset();
        apply_n(HG, 2, 1'b1); apply_n(HY, 1, 1'b1);
        n_checks++; if (fault !== 1'b0) $display("FAIL short_yel_early: got %0b want 0", fault); else n_pass++;
        apply_n(AR, 1, 1'b1);
        n_checks++; if (fault !== 1'b1) $display("FAIL short_yel_fault: got %0b want 1", fault); else n_pass++;
        n_checks++; if (fault_code !== 3'd4) $display("FAIL short_yel_code: got %0d want 4", fault_code); else n_pass++;
    endtask

    task automatic test_bad_jump_clear();
        do_reset();
        apply_n(HG, 1, 1'b1);
        min_ring();
        apply_n(SG, 1, 1'b1);
        n_checks++; if (fault_code !== 3'd3) $display("FAIL jump_code: got %0d want 3", fault_code); else n_pass++;
        apply(2'd3, 2'd0, 1'b1, 1'b0);
        n_checks++; if (fault_code !== 3'd3) $display("FAIL jump_sticky: got %0d want 3", fault_code); else n_pass++;
        apply(HG[3:2], HG[1:0], 1'b1, 1'b1);
        n_checks++; if (fault !== 1'b0) $display("FAIL clr_fault: got %0b want 0", fault); else n_pass++;
        n_checks++; if (fault_code !== 3'd0) $display("FAIL clr_code: got %0d want 0", fault_code); else n_pass++;
        n_checks++; if (phase_count !== 8'd1) $display("FAIL clr_count: got %0d want 1", phase_count); else n_pass++;
        apply_n(SY, 1, 1'b1);
        n_checks++; if (fault !== 1'b0) $display("FAIL clr_sync_ignore: got %0b want 0", fault); else n_pass++;
    endtask

    task automatic test_sync_conflict();
        do_reset();
        apply(2'd2, 2'd1, 1'b1, 1'b0);
        n_checks++; if (fault_code !== 3'd2) $display("FAIL sync_conflict: got %0d want 2", fault_code); else n_pass++;
    endtask

    task automatic test_priority();
        do_reset();
        apply_n(HG, 2, 1'b1);
        apply(2'd3, 2'd2, 1'b1, 1'b0);
        n_checks++; if (fault_code !== 3'd1) $display("FAIL priority_code: got %0d want 1", fault_code); else n_pass++;
    endtask

    task automatic test_sensor();
        logic [2:0] want;
`ifdef MON_SENSOR_CHECK_EN
        want = 3'd6;
`else
        want = 3'd0;
`endif
        do_reset();
        apply_n(HG, 1, 1'b1); apply_n(HY, 2, 1'b1); apply_n(AR, 1, 1'b1);
        apply_n(SG, 1, 1'b0);
        n_checks++; if (fault !== 1'b0) $display("FAIL sensor_early: got %0b want 0", fault); else n_pass++;
        apply_n(SG, 1, 1'b0);
        n_checks++; if (fault_code !== want) $display("FAIL sensor_code: got %0d want %0d", fault_code, want); else n_pass++;
    endtask

    task automatic test_clear_wins();
        do_reset();
        apply_n(HG, 1, 1'b1);
        apply(2'd2, 2'd2, 1'b1, 1'b1);
        n_checks++; if (fault !== 1'b0) $display("FAIL clear_wins_fault: got %0b want 0", fault); else n_pass++;
        n_checks++; if (fault_code !== 3'd0) $display("FAIL clear_wins_code: got %0d want 0", fault_code); else n_pass++;
    endtask

    task automatic test_async_clear();
        do_reset();
        apply_n(HG, 1, 1'b1);
        min_ring();
        apply(2'd2, 2'd2, 1'b1, 1'b0);
        n_checks++; if (fault !== 1'b1) $display("FAIL async_pre_fault: got %0b want 1", fault); else n_pass++;
        #2;
        clr = 1'b1;
        model_reset();
        #1;
        n_checks++; if (fault !== 1'b0) $display("FAIL async_fault: got %0b want 0", fault); else n_pass++;
        n_checks++; if (phase_count !== 8'd0) $display("FAIL async_count: got %0d want 0", phase_count); else n_pass++;
        #1;
        clr = 1'b0;
        apply_n(SG, 1, 1'b1);
        n_checks++; if (fault !== 1'b0) $display("FAIL async_resync: got %0b want 0", fault); else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        apply_n(HG, 1, 1'b1);
        for (int i = 0; i < 256; i++) min_ring();
        n_checks++; if (phase_count !== 8'd255) $display("FAIL saturate_count: got %0d want 255", phase_count); else n_pass++;
        n_checks++; if (fault !== 1'b0) $display("FAIL saturate_fault: got %0b want 0", fault); else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0] cur;
        int rem;
        int r;
        logic sens;
        logic fclr;
        do_reset();
        cur = HG;
        rem = 2;
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                cur = 4'($urandom_range(0, 15));
                rem = 0;
            end else if (rem > 0) begin
                rem--;
            end else begin
                cur = succ(cur);
                rem = int'($urandom_range(0, 3));
            end
            sens = ($urandom_range(0, 3) != 0);
            fclr = (m_faulted != 0 && $urandom_range(0, 7) == 0) || ($urandom_range(0, 199) == 0);
            apply(cur[3:2], cur[1:0], sens, fclr);
            n_checks++; if (fault !== (m_faulted != 0)) $display("FAIL rand_fault[%0d]: got %0b want %0b", i, fault, m_faulted != 0); else n_pass++;
            n_checks++; if (fault_code !== m_code) $display("FAIL rand_code[%0d]: got %0d want %0d", i, fault_code, m_code); else n_pass++;
            n_checks++; if (phase_count !== 8'(m_count)) $display("FAIL rand_count[%0d]: got %0d want %0d", i, phase_count, m_count); else n_pass++;
        end
    endtask

    initial begin
        ring[0] = HG; ring[1] = HY; ring[2] = AR; ring[3] = SG; ring[4] = SY;
        min_dwell[0] = 0; min_dwell[1] = MIN_Y; min_dwell[2] = MIN_A;
        min_dwell[3] = 0; min_dwell[4] = MIN_Y;
        model_reset();
        #1;
        test_reset();
        test_legal_ring();
        test_short_yellow();
        test_bad_jump_clear();
        test_sync_conflict();
        test_priority();
        test_sensor();
        test_clear_wins();
        test_async_clear();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "time limit");
    end

endmodule
